// File: rtl/dexie_cf_checker_if.sv
// Branch-unit to CFI-checker event channel.
// Master drives one control-flow event per cycle; slave returns a stall request.
// cf_stall is advisory: events sent while the checker FIFO is full are dropped and flagged.
interface dexie_cf_checker_if;
  logic        cf_valid;
  logic [31:0] cf_cur_pc;
  logic [31:0] cf_cur_instruction;
  logic [31:0] cf_next_pc;
  logic        cf_resync;
  logic        cf_stall;

  modport master (
    output cf_valid, cf_cur_pc, cf_cur_instruction, cf_next_pc, cf_resync,
    input  cf_stall
  );

  modport slave (
    input  cf_valid, cf_cur_pc, cf_cur_instruction, cf_next_pc, cf_resync,
    output cf_stall
  );
endinterface

// File: rtl/dexie_cf_checker.sv
// Control-flow integrity checker: PC continuity plus shadow call stack on buffered branch events.
// Latency: an event pushed into an empty FIFO in cycle N is checked in N+1; sticky outputs update from N+2.
// Backpressure: registered cf_stall at occupancy >= FIFO_DEPTH-1; events arriving while full are dropped and flagged.
module dexie_cf_checker #(
  parameter int FIFO_DEPTH  = 4,
  parameter int STACK_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  dexie_cf_checker_if.slave  cf,
  input  logic               clear,
  input  logic               pop_hold_i,
  output logic               violation,
  output logic [3:0]         violation_type,
  output logic [31:0]        violation_pc,
  output logic [31:0]        violation_target,
  output logic [31:0]        events_checked
);
  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SAW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [FAW:0] OCC_FULL  = (FAW+1)'(FIFO_DEPTH);
  localparam logic [FAW:0] OCC_STALL = (FAW+1)'(FIFO_DEPTH - 1);
  localparam logic [SAW:0] STK_FULL  = (SAW+1)'(STACK_DEPTH);
  localparam logic [6:0]   OPC_JAL   = 7'b1101111;
  localparam logic [6:0]   OPC_JALR  = 7'b1100111;

  typedef struct packed {
    logic [31:0] cur_pc;
    logic [31:0] instr;
    logic [31:0] next_pc;
  } cf_evt_t;

  // Event FIFO
  cf_evt_t        fifo_mem_q [FIFO_DEPTH];
  logic [FAW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [FAW:0]   fifo_occ_q, fifo_occ_d;
  logic           stall_q, stall_d;

  // Shadow call stack: sp points at the next free slot, cnt saturates when full
  logic [31:0]    stk_mem_q [STACK_DEPTH];
  logic [SAW-1:0] stk_sp_q, stk_sp_d, stk_top, stk_sp_mid;
  logic [SAW:0]   stk_cnt_q, stk_cnt_d, stk_cnt_mid;

  // Continuity expectation and sticky reporting state
  logic        exp_vld_q, exp_vld_d;
  logic [31:0] exp_pc_q, exp_pc_d;
  logic        viol_q, viol_d;
  logic [3:0]  vtype_q, vtype_d;
  logic [31:0] vpc_q, vpc_d, vtgt_q, vtgt_d;
  logic [31:0] evcnt_q, evcnt_d;

  cf_evt_t     in_evt, head;
  logic        do_push, do_pop, drop;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1;
  logic        rd_link, rs1_link, is_jal, is_jalr;
  logic        stk_push, stk_pop, stk_has, stk_pop_ok;
  logic        discont, ret_mis, underflow;
  logic [3:0]  flags;
  logic [31:0] ret_addr;
  logic        unused_instr;

  // FIFO handshake: push when room or when the head leaves this cycle; drop otherwise
  always_comb begin
    in_evt     = '{cur_pc: cf.cf_cur_pc, instr: cf.cf_cur_instruction, next_pc: cf.cf_next_pc};
    head       = fifo_mem_q[fifo_rd_q];
    do_pop     = (fifo_occ_q != '0) && !pop_hold_i;
    do_push    = cf.cf_valid && ((fifo_occ_q != OCC_FULL) || do_pop);
    drop       = cf.cf_valid && (fifo_occ_q == OCC_FULL) && !do_pop;
    fifo_rd_d  = do_pop  ? fifo_rd_q + FAW'(1) : fifo_rd_q;
    fifo_wr_d  = do_push ? fifo_wr_q + FAW'(1) : fifo_wr_q;
    fifo_occ_d = fifo_occ_q + (FAW+1)'(do_push) - (FAW+1)'(do_pop);
    stall_d    = (fifo_occ_d >= OCC_STALL);
  end

  // Classify the checked event as call, return, both, or neither
  always_comb begin
    opc      = head.instr[6:0];
    rd       = head.instr[11:7];
    rs1      = head.instr[19:15];
    rd_link  = (rd == 5'd1) || (rd == 5'd5);
    rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
    is_jal   = (opc == OPC_JAL);
    is_jalr  = (opc == OPC_JALR);
    stk_push = do_pop && (is_jal || is_jalr) && rd_link;
    // a link-to-same-link JALR is a call only; a distinct link pair pops then pushes
    stk_pop  = do_pop && is_jalr && rs1_link && (!rd_link || (rs1 != rd));
  end

  assign unused_instr = ^{head.instr[31:20], head.instr[14:12]};

  // Shadow stack update: pop (if any) first, then push onto the post-pop pointer
  always_comb begin
    stk_has     = (stk_cnt_q != '0);
    stk_top     = stk_sp_q - SAW'(1);
    stk_pop_ok  = stk_pop && stk_has;
    underflow   = stk_pop && !stk_has;
    ret_mis     = stk_pop_ok && (stk_mem_q[stk_top] != {head.next_pc[31:1], 1'b0});
    stk_sp_mid  = stk_pop_ok ? stk_top : stk_sp_q;
    stk_cnt_mid = stk_pop_ok ? stk_cnt_q - (SAW+1)'(1) : stk_cnt_q;
    ret_addr    = head.cur_pc + 32'd4;
    stk_sp_d    = stk_sp_mid;
    stk_cnt_d   = stk_cnt_mid;
    if (stk_push) begin
      // when full the write lands on the oldest entry, so only the count saturates
      stk_sp_d = stk_sp_mid + SAW'(1);
      if (stk_cnt_mid != STK_FULL) begin
        stk_cnt_d = stk_cnt_mid + (SAW+1)'(1);
      end
    end
  end

  // Continuity expectation and sticky violation bookkeeping
  always_comb begin
    discont   = do_pop && exp_vld_q && (head.cur_pc != exp_pc_q);
    flags     = {drop, underflow, ret_mis, discont};
    exp_pc_d  = do_pop ? head.next_pc : exp_pc_q;
    // resync/clear invalidate after the checked event has loaded its successor
    exp_vld_d = (do_pop || exp_vld_q) && !cf.cf_resync && !clear;
    evcnt_d   = do_pop ? evcnt_q + 32'd1 : evcnt_q;
    viol_d    = viol_q;
    vtype_d   = vtype_q;
    vpc_d     = vpc_q;
    vtgt_d    = vtgt_q;
    if (clear) begin
      viol_d  = 1'b0;
      vtype_d = 4'd0;
      vpc_d   = 32'd0;
      vtgt_d  = 32'd0;
    end else if (flags != 4'd0) begin
      viol_d  = 1'b1;
      vtype_d = vtype_q | flags;
      if (!viol_q) begin
        // the checked head is older than a dropped arrival, so it is reported first
        if (flags[2:0] != 3'd0) begin
          vpc_d  = head.cur_pc;
          vtgt_d = head.next_pc;
        end else begin
          vpc_d  = cf.cf_cur_pc;
          vtgt_d = cf.cf_next_pc;
        end
      end
    end
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_occ_q <= '0;
      stall_q    <= 1'b0;
      stk_sp_q   <= '0;
      stk_cnt_q  <= '0;
      exp_vld_q  <= 1'b0;
      exp_pc_q   <= 32'd0;
      viol_q     <= 1'b0;
      vtype_q    <= 4'd0;
      vpc_q      <= 32'd0;
      vtgt_q     <= 32'd0;
      evcnt_q    <= 32'd0;
    end else begin
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_occ_q <= fifo_occ_d;
      stall_q    <= stall_d;
      stk_sp_q   <= stk_sp_d;
      stk_cnt_q  <= stk_cnt_d;
      exp_vld_q  <= exp_vld_d;
      exp_pc_q   <= exp_pc_d;
      viol_q     <= viol_d;
      vtype_q    <= vtype_d;
      vpc_q      <= vpc_d;
      vtgt_q     <= vtgt_d;
      evcnt_q    <= evcnt_d;
    end
  end

  // Storage arrays; contents are meaningless while the pointers say empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem_q[fifo_wr_q] <= in_evt;
    end
    if (stk_push) begin
      stk_mem_q[stk_sp_mid] <= ret_addr;
    end
  end

  assign cf.cf_stall        = stall_q;
  assign violation          = viol_q;
  assign violation_type     = vtype_q;
  assign violation_pc       = vpc_q;
  assign violation_target   = vtgt_q;
  assign events_checked     = evcnt_q;
endmodule

// File: tb/tb_dexie_cf_checker.sv
// Bench for dexie_cf_checker: directed scenarios followed by random traffic.
// Expected outputs come from a queue-based reference model evaluated every clock.
module tb_dexie_cf_checker;
  localparam int FD = 4;
  localparam int SD = 8;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] JAL_X1    = 32'h0000_00EF;
  localparam logic [31:0] RET_X1    = 32'h0000_8067;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, pop_hold;
  logic        violation;
  logic [3:0]  vtype;
  logic [31:0] vpc, vtgt, evcnt;

  dexie_cf_checker_if cf_if ();

  dexie_cf_checker #(.FIFO_DEPTH(FD), .STACK_DEPTH(SD)) dut (
    .clk              (clk),
    .rst              (rst),
    .cf               (cf_if),
    .clear            (clear),
    .pop_hold_i       (pop_hold),
    .violation        (violation),
    .violation_type   (vtype),
    .violation_pc     (vpc),
    .violation_target (vtgt),
    .events_checked   (evcnt)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] nxt;
  } ev_t;

  ev_t         m_fifo [$];
  logic [31:0] m_stk [$];
  bit          m_exp_vld, m_viol, m_stall;
  logic [31:0] m_exp_pc, m_vpc, m_vtgt, m_cnt;
  logic [3:0]  m_type;

  function automatic bit is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Reference model: advance one clock using the inputs presented this cycle
  task automatic model_step();
    ev_t e, inb;
    bit popping, is_call, is_ret;
    int occ0;
    logic [3:0]  f;
    logic [31:0] fpc, ftgt, top;
    logic [4:0]  rd, rs1;
    if (rst) begin
      m_fifo.delete(); m_stk.delete();
      m_exp_vld = 0; m_exp_pc = 0; m_viol = 0; m_type = 0;
      m_vpc = 0; m_vtgt = 0; m_cnt = 0; m_stall = 0;
      return;
    end
    f = 4'd0; fpc = 0; ftgt = 0;
    occ0 = m_fifo.size();
    popping = (occ0 > 0) && !pop_hold;
    inb.pc = cf_if.cf_cur_pc; inb.ins = cf_if.cf_cur_instruction; inb.nxt = cf_if.cf_next_pc;
    if (popping) begin
      e = m_fifo.pop_front();
      m_cnt = m_cnt + 32'd1;
      if (m_exp_vld && e.pc != m_exp_pc) f[0] = 1'b1;
      m_exp_pc = e.nxt; m_exp_vld = 1;
      rd = e.ins[11:7]; rs1 = e.ins[19:15];
      is_call = (e.ins[6:0] == 7'b1101111 || e.ins[6:0] == 7'b1100111) && is_link(rd);
      is_ret  = (e.ins[6:0] == 7'b1100111) && is_link(rs1) && !(is_link(rd) && rs1 == rd);
      if (is_ret) begin
        if (m_stk.size() == 0) f[2] = 1'b1;
        else begin
          top = m_stk.pop_back();
          if (top != {e.nxt[31:1], 1'b0}) f[1] = 1'b1;
        end
      end
      if (is_call) begin
        if (m_stk.size() == SD) void'(m_stk.pop_front());
        m_stk.push_back(e.pc + 32'd4);
      end
      if (f != 0) begin fpc = e.pc; ftgt = e.nxt; end
    end
    if (cf_if.cf_valid) begin
      if (occ0 < FD || popping) m_fifo.push_back(inb);
      else begin
        f[3] = 1'b1;
        if (f[2:0] == 0) begin fpc = inb.pc; ftgt = inb.nxt; end
      end
    end
    if (cf_if.cf_resync || clear) m_exp_vld = 0;
    if (clear) begin
      m_viol = 0; m_type = 0; m_vpc = 0; m_vtgt = 0;
    end else if (f != 0) begin
      if (!m_viol) begin m_vpc = fpc; m_vtgt = ftgt; end
      m_viol = 1; m_type = m_type | f;
    end
    m_stall = (m_fifo.size() >= FD - 1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("violation", 32'(violation), 32'(m_viol));
    chk("violation_type", 32'(vtype), 32'(m_type));
    chk("violation_pc", vpc, m_vpc);
    chk("violation_target", vtgt, m_vtgt);
    chk("events_checked", evcnt, m_cnt);
    chk("cf_stall", 32'(cf_if.cf_stall), 32'(m_stall));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk_all();
  endtask

  task automatic idle();
    cf_if.cf_valid = 0; cf_if.cf_resync = 0; clear = 0;
    cf_if.cf_cur_pc = 0; cf_if.cf_cur_instruction = NOP; cf_if.cf_next_pc = 0;
  endtask

  task automatic idles(input int n);
    idle();
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic ev(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] nxt);
    cf_if.cf_valid = 1; cf_if.cf_cur_pc = pc; cf_if.cf_cur_instruction = ins; cf_if.cf_next_pc = nxt;
    step();
    idle();
  endtask

  task automatic do_reset();
    idle(); pop_hold = 0; rst = 1;
    step(); step();
    rst = 0;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd1;
      1: return 5'd5;
      2: return 5'd0;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    logic [31:0] last_nxt, cur, nxt, ins;
    logic [6:0]  opc;
    rst = 1; clear = 0; pop_hold = 0;
    idle();
    do_reset();
    chk("reset_violation", 32'(violation), 32'd0);
    chk("reset_count", evcnt, 32'd0);

    // sequential flow stays clean
    ev(32'h100, NOP, 32'h104); ev(32'h104, NOP, 32'h200); ev(32'h200, NOP, 32'h204);
    idles(3);
    chk("seq_violation", 32'(violation), 32'd0);
    chk("seq_count", evcnt, 32'd3);

    // matched call/return
    do_reset();
    ev(32'h1000, JAL_X1, 32'h2000); ev(32'h2000, RET_X1, 32'h1004);
    idles(3);
    chk("ret_ok_violation", 32'(violation), 32'd0);
    // mismatched return
    do_reset();
    ev(32'h1000, JAL_X1, 32'h2000); ev(32'h2000, RET_X1, 32'h1008);
    idles(3);
    chk("ret_bad_type", 32'(vtype), 32'h2);
    chk("ret_bad_pc", vpc, 32'h2000);
    chk("ret_bad_target", vtgt, 32'h1008);

    // discontinuity, then the same jump bridged by a resync
    do_reset();
    ev(32'h100, NOP, 32'h104); ev(32'h300, NOP, 32'h304);
    idles(3);
    chk("discont_type", 32'(vtype), 32'h1);
    chk("discont_pc", vpc, 32'h300);
    do_reset();
    ev(32'h100, NOP, 32'h104); idles(1);
    cf_if.cf_resync = 1; step(); idle();
    ev(32'h300, NOP, 32'h304);
    idles(3);
    chk("resync_violation", 32'(violation), 32'd0);

    // underflow then clear
    do_reset();
    ev(32'h500, RET_X1, 32'h600);
    idles(3);
    chk("underflow_type", 32'(vtype), 32'h4);
    clear = 1; step(); clear = 0;
    chk("clear_violation", 32'(violation), 32'd0);
    chk("clear_type", 32'(vtype), 32'd0);
    chk("clear_pc", vpc, 32'd0);
    chk("clear_target", vtgt, 32'd0);

    // overflow with the check stage held
    do_reset();
    pop_hold = 1;
    ev(32'h10, NOP, 32'h14); chk("stall_occ1", 32'(cf_if.cf_stall), 32'd0);
    ev(32'h14, NOP, 32'h18); chk("stall_occ2", 32'(cf_if.cf_stall), 32'd0);
    ev(32'h18, NOP, 32'h1c); chk("stall_occ3", 32'(cf_if.cf_stall), 32'd1);
    ev(32'h1c, NOP, 32'h20); chk("full_no_viol", 32'(violation), 32'd0);
    ev(32'h20, NOP, 32'h24);
    chk("ovf_type", 32'(vtype), 32'h8);
    chk("ovf_pc", vpc, 32'h20);
    chk("ovf_target", vtgt, 32'h24);
    pop_hold = 0;
    idles(6);
    chk("ovf_drain_count", evcnt, 32'd4);
    chk("ovf_drain_stall", 32'(cf_if.cf_stall), 32'd0);

    // random traffic against the model
    do_reset();
    last_nxt = 32'h100;
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      clear    = ($urandom_range(0, 49) == 0);
      pop_hold = ($urandom_range(0, 3) == 0);
      cf_if.cf_resync = ($urandom_range(0, 29) == 0);
      cf_if.cf_valid  = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 4))
        0: opc = 7'b1101111;
        1, 2: opc = 7'b1100111;
        3: opc = 7'h13;
        default: opc = 7'($urandom_range(0, 127));
      endcase
      ins = {12'($urandom_range(0, 4095)), pick_reg(), 3'b000, pick_reg(), opc};
      cur = ($urandom_range(0, 9) < 8) ? last_nxt : {$urandom_range(0, 32'hFFFF), 2'b00};
      if (m_stk.size() > 0 && $urandom_range(0, 1) == 1) nxt = m_stk[$] | 32'($urandom_range(0, 1));
      else if ($urandom_range(0, 2) == 0) nxt = $urandom();
      else nxt = cur + 32'd4;
      cf_if.cf_cur_pc = cur; cf_if.cf_cur_instruction = ins; cf_if.cf_next_pc = nxt;
      if (cf_if.cf_valid) last_nxt = nxt;
      step();
    end
    rst = 0; pop_hold = 0;
    idles(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dexie_cf_checker.md
DEXIE_CF_CHECKER -- requirements
Module: dexie_cf_checker

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-002 Parameter STACK_DEPTH, default 8, shadow call stack entries (power of two).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cf_valid  in  1  control-flow event strobe from branch unit, one event per cycle.
REQ-006 cf_cur_pc  in  32  PC of the retiring-order instruction.
REQ-007 cf_cur_instruction  in  32  instruction word at cf_cur_pc.
REQ-008 cf_next_pc  in  32  resolved successor PC.
REQ-009 cf_resync  in  1  trap/redirect notice; invalidates continuity expectation.
REQ-010 clear  in  1  clears sticky violation state.
REQ-011 cf_stall  out  1  back-pressure request to the core.
REQ-012 violation  out  1  sticky, any violation since reset/clear.
REQ-013 violation_type  out  4  sticky OR: [0] discontinuity, [1] return mismatch, [2] stack underflow, [3] FIFO overflow.
REQ-014 violation_pc  out  32  cur_pc of first violating event.
REQ-015 violation_target  out  32  next_pc of first violating event.
REQ-016 events_checked  out  32  count of events popped and checked, wraps at 2^32.

Function
REQ-017 Every cf_valid cycle with FIFO not full SHALL push {cur_pc, instruction, next_pc}.
REQ-018 cf_valid with FIFO full and no pop that cycle SHALL drop the event and set violation_type[3]; full with simultaneous pop SHALL accept the push.
REQ-019 Check stage SHALL pop and check the FIFO head every cycle the FIFO is non-empty (one event/cycle).
REQ-020 Latency: event pushed in cycle N into empty FIFO is checked in N+1; resulting outputs visible from N+2.
REQ-021 cf_stall SHALL be registered, high when occupancy after the current cycle's push/pop >= FIFO_DEPTH-1.
REQ-022 Continuity: expected_pc register with valid bit; checked event with valid expectation and cur_pc != expected_pc SHALL set type[0]; every checked event loads expected_pc <= next_pc, valid <= 1.
REQ-023 Expectation valid SHALL clear on rst, clear, and cf_resync; cf_resync with a pop in the same cycle SHALL invalidate after the checked event loads (resync wins).
REQ-024 Link register = x1 or x5; opcode 1101111 JAL, 1100111 JALR.
REQ-025 Call: JAL/JALR with rd link SHALL push cur_pc+4 (32-bit wrap).
REQ-026 Return: JALR with rs1 link and rd not link SHALL pop and compare to next_pc with bit 0 forced 0; mismatch sets type[1].
REQ-027 JALR with rd and rs1 both link, rs1 != rd: pop (compare as REQ-026) then push in the same check; rs1 == rd: push only.
REQ-028 Pop on empty stack SHALL set type[2], no compare, pointer unchanged.
REQ-029 Push on full stack SHALL overwrite oldest entry (circular); no violation; count saturates at STACK_DEPTH.
REQ-030 Non-call/non-return events SHALL not touch the stack.
REQ-031 violation_pc/target SHALL capture only when violation transitions 0->1; later violations only OR type bits.
REQ-032 clear SHALL zero violation, type, pc, target next cycle; violations detected in the clear cycle discarded; FIFO, stack, counter unaffected.

Reset
REQ-033 rst SHALL empty FIFO and stack, invalidate expectation, zero all outputs (cf_stall 0, events_checked 0), dropping in-flight events; rst mid-operation has same effect.

Verification
REQ-034 Sequential events 0x100->0x104, 0x104->0x200, 0x200->0x204 -> violation stays 0, events_checked=3.
REQ-035 JAL x1 at 0x1000 (next 0x2000), then JALR x0,0(x1) at 0x2000 with next 0x1004 -> no violation; same with next 0x1008 -> violation_type=0010, violation_pc=0x2000, violation_target=0x1008.
REQ-036 Event 0x100->0x104 then 0x300->0x304 -> type[0] set, violation_pc=0x300; repeat with cf_resync between -> no violation.
REQ-037 Return with empty stack -> type=0100; then clear -> all sticky outputs 0 next cycle.
REQ-038 FIFO_DEPTH=4, hold check stage by back-to-back pushes with stall ignored (force pop-disable in bench hook or drive cf_valid while occupancy 4) -> cf_stall high at occupancy 3, dropped event sets type[3].
